image_downsample_cpu: RTL and testbench

- Fixed-function image processor behind a 2-bit command bus.
- Accepts a 256x256 8-bit greyscale image into internal memory.
- Applies a 3x3 Gaussian filter at stride 2, producing a 127x127 image, and signals completion.
- Serves the result back one byte per address; sits between a host/loader and an output-dump consumer.

---
 rtl/img_cpu_pkg.sv | 47 ++++
 rtl/image_downsample_cpu_byte_ram.sv | 44 ++++
 rtl/image_downsample_cpu.sv | 172 +++++++++++++++++
 tb/tb_image_downsample_cpu.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/img_cpu_pkg.sv
// Shared encodings, FSM states and the 3x3 Gaussian kernel for the image downsampler.
package img_cpu_pkg;

  localparam int IMG_W_DEF = 256;
  localparam int OUT_W_DEF = 127;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b10;
  localparam logic [1:0] ST_PROC = 2'b01;
  localparam logic [1:0] ST_READ = 2'b11;

  localparam logic [3:0] LAST_TAP = 4'd8;
  localparam logic [3:0] WRITE_CYC = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Kernel 1 2 1 / 2 4 2 / 1 2 1 indexed by tap number in row-major order.
  function automatic logic [2:0] kernel_weight(input logic [3:0] tap);
    case (tap)
      4'd0, 4'd2, 4'd6, 4'd8: return 3'd1;
      4'd1, 4'd3, 4'd5, 4'd7: return 3'd2;
      4'd4:                   return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] tap_row(input logic [3:0] tap);
    case (tap)
      4'd3, 4'd4, 4'd5: return 2'd1;
      4'd6, 4'd7, 4'd8: return 2'd2;
      default:          return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tap_col(input logic [3:0] tap);
    case (tap)
      4'd1, 4'd4, 4'd7: return 2'd1;
      4'd2, 4'd5, 4'd8: return 2'd2;
      default:          return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/image_downsample_cpu_byte_ram.sv
// Single-port byte RAM with registered read; the read register can be loaded with zero
// instead of the array word so callers can blank out-of-range reads.
module byte_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic          rz,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;
  logic [7:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rz ? 8'd0 : mem[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 8'd0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/image_downsample_cpu.sv
// Command-driven image processor: load an IMG_W x IMG_W image, run a stride-2 3x3
// Gaussian to OUT_W x OUT_W, then serve the result one byte per address.
module image_downsample_cpu
  import img_cpu_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  status,
  input  logic [7:0]  data,
  input  logic [15:0] addr,
  output logic        end_process,
  output logic [7:0]  out
);

  localparam int IN_DEPTH  = IMG_W * IMG_W;
  localparam int OUT_DEPTH = OUT_W * OUT_W;
  localparam int IN_AW     = $clog2(IN_DEPTH);
  localparam int OUT_AW    = $clog2(OUT_DEPTH);
  localparam int CW        = $clog2(OUT_W);

  state_e            state_q, state_d;
  logic [CW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [3:0]        k_q, k_d;
  logic [11:0]       acc_q, acc_d;
  logic [OUT_AW-1:0] oaddr_q, oaddr_d;
  logic              fin_q, fin_d;
  logic              end_process_q, end_process_d;

  logic [IN_AW-1:0]  tap_addr;
  logic [IN_AW-1:0]  in_addr;
  logic [7:0]        in_rdata;
  logic              in_we;
  logic              in_re;
  logic [OUT_AW-1:0] out_addr;
  logic              out_we;
  logic              out_re;
  logic              out_rz;
  logic [3:0]        w_idx;
  logic [11:0]       acc_sum;

  // Address for tap k of the window at (2r, 2c); the RAM returns it one cycle later.
  assign tap_addr = IN_AW'((32'(r_q) * 32'd2 + 32'(tap_row(k_q))) * 32'(IMG_W)
                           + 32'(c_q) * 32'd2 + 32'(tap_col(k_q)));

  assign in_we    = (status == ST_LOAD) && (state_q != S_RUN);
  assign in_re    = (state_q == S_RUN);
  assign in_addr  = (state_q == S_RUN) ? tap_addr : addr[IN_AW-1:0];

  assign out_re   = (status == ST_READ) && (state_q != S_RUN);
  assign out_rz   = 32'(addr) >= 32'(OUT_DEPTH);
  assign out_addr = (state_q == S_RUN) ? oaddr_q : addr[OUT_AW-1:0];

  // Data on in_rdata during cycle k belongs to tap k-1.
  assign w_idx    = k_q - 4'd1;
  assign acc_sum  = acc_q + 12'(kernel_weight(w_idx)) * 12'(in_rdata);

  byte_ram #(.DEPTH(IN_DEPTH)) u_in_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (in_we),
    .re    (in_re),
    .rz    (1'b0),
    .addr  (in_addr),
    .wdata (data),
    .rdata (in_rdata)
  );

  byte_ram #(.DEPTH(OUT_DEPTH)) u_out_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (out_we),
    .re    (out_re),
    .rz    (out_rz),
    .addr  (out_addr),
    .wdata (acc_sum[11:4]),
    .rdata (out)
  );

  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    c_d           = c_q;
    k_d           = k_q;
    acc_d         = acc_q;
    oaddr_d       = oaddr_q;
    fin_d         = fin_q;
    end_process_d = end_process_q;
    out_we        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (status == ST_PROC) begin
          state_d = S_RUN;
          r_d     = '0;
          c_d     = '0;
          k_d     = 4'd0;
          acc_d   = 12'd0;
          oaddr_d = '0;
          fin_d   = 1'b0;
        end
      end

      S_RUN: begin
        if (fin_q) begin
          // One settle cycle after the last write keeps the completion edge count fixed.
          state_d       = S_DONE;
          end_process_d = 1'b1;
          fin_d         = 1'b0;
        end else if (k_q == WRITE_CYC) begin
          out_we  = 1'b1;
          acc_d   = 12'd0;
          k_d     = 4'd0;
          oaddr_d = oaddr_q + 1'b1;
          if (c_q == CW'(OUT_W - 1)) begin
            c_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
          if (oaddr_q == OUT_AW'(OUT_DEPTH - 1)) begin
            fin_d = 1'b1;
          end
        end else begin
          if (k_q != 4'd0) begin
            acc_d = acc_sum;
          end
          k_d = k_q + 4'd1;
        end
      end

      S_DONE: begin
        if (status == ST_LOAD) begin
          state_d       = S_IDLE;
          end_process_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      r_q           <= '0;
      c_q           <= '0;
      k_q           <= 4'd0;
      acc_q         <= 12'd0;
      oaddr_q       <= '0;
      fin_q         <= 1'b0;
      end_process_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      c_q           <= c_d;
      k_q           <= k_d;
      acc_q         <= acc_d;
      oaddr_q       <= oaddr_d;
      fin_q         <= fin_d;
      end_process_q <= end_process_d;
    end
  end

  assign end_process = end_process_q;

endmodule

// File: tb/tb_image_downsample_cpu.sv
// Directed bench for image_downsample_cpu on a reduced 32x32 -> 15x15 geometry.
module tb_image_downsample_cpu;
  import img_cpu_pkg::*;

  localparam int IMG_W     = 32;
  localparam int OUT_W     = 15;
  localparam int NPIX      = IMG_W * IMG_W;
  localparam int NOUT      = OUT_W * OUT_W;
  localparam int RUN_EDGES = 1 + NOUT * 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  status;
  logic [7:0]  data;
  logic [15:0] addr;
  logic        end_process;
  logic [7:0]  out;

  int tests = 0;
  int fails = 0;
  logic [7:0] img [NPIX];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  image_downsample_cpu #(.IMG_W(IMG_W), .OUT_W(OUT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .status      (status),
    .data        (data),
    .addr        (addr),
    .end_process (end_process),
    .out         (out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input int r, input int c);
    int w [3] = '{1, 2, 1};
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += w[i] * w[j] * int'(img[(2 * r + i) * IMG_W + 2 * c + j]);
    return 8'(s >> 4);
  endfunction

  function automatic logic [7:0] expect_px(input int mode, input int a);
    int r = a / OUT_W;
    int c = a % OUT_W;
    case (mode)
      0:       return 8'd100;
      1:       return (a == 0) ? 8'd40 : 8'd0;
      2:       return 8'(2 * c + 1);
      3:       return model(r, c);
      default: return 8'd255;
    endcase
  endfunction

  task automatic load_image();
    for (int i = 0; i < NPIX; i++) begin
      status = ST_LOAD;
      addr   = 16'(i);
      data   = img[i];
      tick();
      if (i == 0) check("load_clears_done", 32'(end_process), 0);
    end
    status = ST_IDLE;
  endtask

  task automatic run_process(input string tag);
    int cnt = 0;
    status = ST_PROC;
    tick();
    status = ST_IDLE;
    while (!end_process && cnt < RUN_EDGES + 20) begin
      tick();
      cnt++;
    end
    check(tag, cnt, RUN_EDGES);
  endtask

  task automatic rd(input int a, input logic [7:0] e, input string tag);
    status = ST_READ;
    addr   = 16'(a);
    exp_q.push_back(e);
    tick();
    check(tag, 32'(out), 32'(exp_q.pop_front()));
  endtask

  task automatic read_all(input int mode, input string tag);
    for (int a = 0; a < NOUT; a++)
      rd(a, expect_px(mode, a), $sformatf("%s[%0d]", tag, a));
    status = ST_IDLE;
  endtask

  initial begin
    rst = 1'b1; status = ST_IDLE; data = 8'd0; addr = 16'd0;
    repeat (3) tick();
    check("reset_end_process", 32'(end_process), 0);
    check("reset_out", 32'(out), 0);
    rst = 1'b0;
    tick();

    // Constant image
    for (int i = 0; i < NPIX; i++) img[i] = 8'd100;
    load_image();
    run_process("const_edges");
    read_all(0, "const");
    check("done_holds_after_read", 32'(end_process), 1);
    repeat (3) tick();
    check("done_holds_idle", 32'(end_process), 1);
    check("out_holds_idle", 32'(out), 100);
    rd(NOUT, 8'd0, "read_out_of_range");
    rd(0, 8'd100, "read_after_oob");
    status = ST_PROC;
    repeat (20) tick();
    status = ST_IDLE;
    tick();
    check("proc_in_done_ignored", 32'(end_process), 1);

    // Impulse at (1,1)
    for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
    img[IMG_W + 1] = 8'd160;
    load_image();
    check("load_left_done", 32'(end_process), 0);
    run_process("impulse_edges");
    read_all(1, "impulse");

    // Column gradient
    for (int i = 0; i < NPIX; i++) img[i] = 8'(i % IMG_W);
    load_image();
    run_process("gradient_edges");
    read_all(2, "gradient");
    rd(5, 8'd11, "gradient_pick");

    // Random image, reset mid-run, then rerun
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
    load_image();
    status = ST_PROC;
    tick();
    status = ST_LOAD; addr = 16'd0; data = ~img[0];
    repeat (5) tick();
    status = ST_READ; addr = 16'd0;
    repeat (5) tick();
    check("run_read_ignored", 32'(out), 11);
    status = ST_IDLE;
    repeat (990) tick();
    check("mid_run_not_done", 32'(end_process), 0);
    rst = 1'b1;
    #2;
    check("rst_mid_run_end_process", 32'(end_process), 0);
    check("rst_mid_run_out", 32'(out), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_process("rerun_edges");
    read_all(3, "random");

    // All-255 image: largest accumulator, old results fully overwritten
    for (int i = 0; i < NPIX; i++) img[i] = 8'd255;
    load_image();
    run_process("max_edges");
    read_all(4, "max");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
